// File: rtl/i2s_pkg.sv
// Purpose: shared types and constants for the I2S transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   SLOT_WIDTH   - default I2S slot width in bit clocks
//   FRAME_BITS   - default frame length (left slot + right slot)
//   fill_state_t - staging FSM state for the frame stager
//   sample_t     - default-width two's complement audio sample
package i2s_pkg;

    localparam int SLOT_WIDTH = 16;
    localparam int FRAME_BITS = 32;

    typedef enum logic [1:0] {
        WAIT_L = 2'd0,
        WAIT_R = 2'd1,
        FULL   = 2'd2
    } fill_state_t;

    typedef logic signed [SLOT_WIDTH-1:0] sample_t;

endpackage

// File: rtl/i2s_frame_stager.sv
// Purpose: pops samples from the CDC FIFO and stages one L/R pair for the next frame.
// Latency: a popped word is visible on stagedL/stagedR one cycle after the pop edge.
// Backpressure: no pops while a full pair is staged; the FIFO simply holds its data.
//
// Ports:
//   clkI2SBit  - I2S bit clock, rising edge
//   rstI2S     - asynchronous active-high reset
//   pkt        - FIFO read data
//   pktValid   - FIFO non-empty
//   frameLatch - the top-level frame register loads on this edge
//   pktRead    - pop strobe (combinational)
//   stagedFull - a complete pair is staged
//   stagedL/R  - staged left / right samples
module i2s_frame_stager
    import i2s_pkg::*;
#(
    parameter int PKT_WIDTH = SLOT_WIDTH,
    parameter bit STEREO    = 1'b1
) (
    input  logic                 clkI2SBit,
    input  logic                 rstI2S,
    input  logic [PKT_WIDTH-1:0] pkt,
    input  logic                 pktValid,
    input  logic                 frameLatch,
    output logic                 pktRead,
    output logic                 stagedFull,
    output logic [PKT_WIDTH-1:0] stagedL,
    output logic [PKT_WIDTH-1:0] stagedR
);

    fill_state_t state;
    fill_state_t stateNext;

    always_ff @(posedge clkI2SBit or posedge rstI2S) begin
        if (rstI2S) begin
            state <= WAIT_L;
        end else begin
            state <= stateNext;
        end
    end

    // A pop is suppressed while in reset so nothing leaves the FIFO
    // that the staging registers could not keep.
    always_comb begin
        stateNext = state;
        pktRead   = pktValid && (state != FULL) && !rstI2S;
        if (frameLatch) begin
            // The latch always re-aligns to the left channel. A word popped
            // in this same cycle while not full belongs to the underrun and
            // is dropped here.
            stateNext = WAIT_L;
        end else if (pktRead) begin
            case (state)
                WAIT_L:  stateNext = STEREO ? WAIT_R : FULL;
                WAIT_R:  stateNext = FULL;
                default: stateNext = state;
            endcase
        end
    end

    always_ff @(posedge clkI2SBit or posedge rstI2S) begin
        if (rstI2S) begin
            stagedL <= '0;
            stagedR <= '0;
        end else if (pktRead && !frameLatch) begin
            if (state == WAIT_L) begin
                stagedL <= pkt;
                // Mono streams feed the same sample to both channels.
                if (!STEREO) begin
                    stagedR <= pkt;
                end
            end else if (state == WAIT_R) begin
                stagedR <= pkt;
            end
        end
    end

    assign stagedFull = (state == FULL);

endmodule

// File: rtl/i2s_tx_serializer.sv
// Purpose: serialises staged L/R samples onto the I2S DAC interface (ws/sd) with underrun detection.
// Latency: a sample staged before the last slot of a frame starts on sd_o 2 cycles later (slot 1).
// Backpressure: pops only while staging has room; a frame without a full pair is muted and counted.
//
// Ports:
//   clkI2SBit_i   - I2S bit clock, all logic on the rising edge
//   rstI2S_i      - asynchronous active-high reset
//   pkt_i         - FIFO read data (two's complement)
//   pktValid_i    - FIFO non-empty
//   pktRead_o     - pop strobe, combinational
//   ws_o          - word select, 0 = left, 1 = right
//   sd_o          - serial data, MSB first, one bit after the ws edge
//   frameStart_o  - one-cycle pulse in slot 0
//   underrun_o    - one-cycle pulse in slot 0 of a muted frame
//   underrunCnt_o - saturating underrun count
module i2s_tx_serializer
    import i2s_pkg::*;
#(
    parameter int PKT_WIDTH  = SLOT_WIDTH,
    parameter bit STEREO     = 1'b1,
    parameter int UCNT_WIDTH = 8
) (
    input  logic                  clkI2SBit_i,
    input  logic                  rstI2S_i,
    input  logic [PKT_WIDTH-1:0]  pkt_i,
    input  logic                  pktValid_i,
    output logic                  pktRead_o,
    output logic                  ws_o,
    output logic                  sd_o,
    output logic                  frameStart_o,
    output logic                  underrun_o,
    output logic [UCNT_WIDTH-1:0] underrunCnt_o
);

    localparam int FB = 2 * PKT_WIDTH;
    localparam int SW = $clog2(FB);

    logic [SW-1:0]        slot;
    logic [SW-1:0]        slotNext;
    logic [SW-1:0]        sdIdx;
    logic [FB-1:0]        frameQ;
    logic                 frameLatch;
    logic                 stagedFull;
    logic [PKT_WIDTH-1:0] stagedL;
    logic [PKT_WIDTH-1:0] stagedR;

    assign frameLatch = (slot == SW'(FB - 1));
    assign slotNext   = frameLatch ? '0 : slot + 1'b1;
    // Bit driven out during the next slot: frame bit (FB-1-slot) lands
    // one slot late, which yields the I2S one-bit delay after ws.
    assign sdIdx      = SW'(FB - 1) - slot;

    i2s_frame_stager #(
        .PKT_WIDTH (PKT_WIDTH),
        .STEREO    (STEREO)
    ) u_stager (
        .clkI2SBit  (clkI2SBit_i),
        .rstI2S     (rstI2S_i),
        .pkt        (pkt_i),
        .pktValid   (pktValid_i),
        .frameLatch (frameLatch),
        .pktRead    (pktRead_o),
        .stagedFull (stagedFull),
        .stagedL    (stagedL),
        .stagedR    (stagedR)
    );

    // Slot counter and registered frame-timing outputs. ws_o and
    // frameStart_o are decoded from the next slot so they are aligned
    // with the slot they describe.
    always_ff @(posedge clkI2SBit_i or posedge rstI2S_i) begin
        if (rstI2S_i) begin
            slot         <= '0;
            ws_o         <= 1'b0;
            frameStart_o <= 1'b0;
            sd_o         <= 1'b0;
        end else begin
            slot         <= slotNext;
            ws_o         <= (slotNext >= SW'(PKT_WIDTH));
            frameStart_o <= (slotNext == '0);
            // Uses the frame register before a same-edge reload, so the
            // previous right LSB still goes out in slot 0.
            sd_o         <= frameQ[sdIdx];
        end
    end

    // Frame register: takes the staged pair at the end of each frame,
    // or mutes when the pair is incomplete.
    always_ff @(posedge clkI2SBit_i or posedge rstI2S_i) begin
        if (rstI2S_i) begin
            frameQ <= '0;
        end else if (frameLatch) begin
            frameQ <= stagedFull ? {stagedL, stagedR} : '0;
        end
    end

    // Underrun pulse lines up with frameStart_o; the counter holds at all-ones.
    always_ff @(posedge clkI2SBit_i or posedge rstI2S_i) begin
        if (rstI2S_i) begin
            underrun_o    <= 1'b0;
            underrunCnt_o <= '0;
        end else begin
            underrun_o <= frameLatch && !stagedFull;
            if (frameLatch && !stagedFull && (underrunCnt_o != '1)) begin
                underrunCnt_o <= underrunCnt_o + 1'b1;
            end
        end
    end

endmodule
